// File: rtl/alu_uart_sequencer_if.sv
// alu_uart_sequencer_if: byte stream, transmit handshake and ALU operand/result bus
interface alu_uart_sequencer_if #(parameter int NBITS = 8, parameter int COD_OP = 6);
  logic [NBITS-1:0]  rx_data;
  logic              rx_valid;
  logic              tx_done;
  logic [NBITS-1:0]  tx_data;
  logic              tx_start;
  logic [NBITS-1:0]  operando_A;
  logic [NBITS-1:0]  operando_B;
  logic [COD_OP-1:0] cod_operacion;
  logic [NBITS-1:0]  ALU_Result;
  logic              busy;
  logic              overrun;
  logic [2:0]        state_o;
  modport master (
    input  rx_data, rx_valid, tx_done, ALU_Result,
    output tx_data, tx_start, operando_A, operando_B, cod_operacion, busy, overrun, state_o
  );
  modport slave (
    output rx_data, rx_valid, tx_done, ALU_Result,
    input  tx_data, tx_start, operando_A, operando_B, cod_operacion, busy, overrun, state_o
  );
endinterface

// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: loads A, B, opcode from received bytes and ships the ALU result to the transmitter
module alu_uart_sequencer (
  input logic clk,
  input logic reset_n,
  alu_uart_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_A = 3'd0, S_B = 3'd1, S_OP = 3'd2, S_EXEC = 3'd3, S_WAIT = 3'd4} state_t;
  state_t state, state_n;
  assign bus.busy = (state == S_EXEC) || (state == S_WAIT);
  assign bus.state_o = state;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_A;
    else state <= state_n;
  // next state: one byte per load state, single exec cycle, then wait for the transmitter
  always_comb begin
    state_n = S_A;
    case (state)
      S_A:    state_n = bus.rx_valid ? S_B : S_A;
      S_B:    state_n = bus.rx_valid ? S_OP : S_B;
      S_OP:   state_n = bus.rx_valid ? S_EXEC : S_OP;
      S_EXEC: state_n = S_WAIT;
      S_WAIT: state_n = bus.tx_done ? S_A : S_WAIT;
      default: state_n = S_A;
    endcase
  end
  // operand/opcode loading, result capture, start pulse and sticky overrun
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.operando_A    <= '0;
      bus.operando_B    <= '0;
      bus.cod_operacion <= '0;
      bus.tx_data       <= '0;
      bus.tx_start      <= 1'b0;
      bus.overrun       <= 1'b0;
    end else begin
      bus.tx_start <= state == S_EXEC;
      if (state == S_A && bus.rx_valid) bus.operando_A <= bus.rx_data;
      if (state == S_B && bus.rx_valid) bus.operando_B <= bus.rx_data;
      if (state == S_OP && bus.rx_valid) bus.cod_operacion <= bus.rx_data[$bits(bus.cod_operacion)-1:0];
      if (state == S_EXEC) bus.tx_data <= bus.ALU_Result;
      if (bus.busy && bus.rx_valid) bus.overrun <= 1'b1;
    end
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb_alu_uart_sequencer: directed transactions against a behavioural ALU
module tb_alu_uart_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int passed = 0;
  int total = 0;
  int starts = 0;
  int exp_starts = 0;
  alu_uart_sequencer_if #(.NBITS(8), .COD_OP(6)) bus ();
  alu_uart_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20: alu = a + b;
      6'h22: alu = a - b;
      6'h24: alu = a & b;
      6'h25: alu = a | b;
      6'h26: alu = a ^ b;
      6'h27: alu = ~(a | b);
      6'h03: alu = $unsigned($signed(a) >>> b);
      6'h02: alu = a >> b;
      default: alu = 8'hFF;
    endcase
  endfunction
  assign bus.ALU_Result = alu(bus.operando_A, bus.operando_B, bus.cod_operacion);
  always @(posedge clk) if (bus.tx_start === 1'b1) starts++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                     input logic [7:0] exp, input int dly, input bit ovr);
    send(a);
    send(b);
    bus.rx_data = op;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("exec_state", bus.state_o, 3);
    chk("exec_start_low", bus.tx_start, 0);
    chk("opcode", bus.cod_operacion, op[5:0]);
    @(negedge clk);
    exp_starts++;
    chk("start_high", bus.tx_start, 1);
    chk("tx_data", bus.tx_data, exp);
    chk("busy", bus.busy, 1);
    for (int i = 0; i < dly; i++) begin
      bus.rx_data = 8'h55;
      bus.rx_valid = ovr && i == 0;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (i == 0) chk("start_one_cycle", bus.tx_start, 0);
    end
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk("back_to_a", bus.state_o, 0);
    chk("start_after_done", bus.tx_start, 0);
    chk("held_a", bus.operando_A, a);
  endtask
  initial begin
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.tx_done = 1'b0;
    #1;
    chk("rst_state", bus.state_o, 0);
    chk("rst_start", bus.tx_start, 0);
    chk("rst_txdata", bus.tx_data, 0);
    chk("rst_overrun", bus.overrun, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    chk("done_ignored", bus.state_o, 0);
    txn(8'h05, 8'h03, 8'h20, 8'h08, 10, 0);
    txn(8'h03, 8'h05, 8'h22, 8'hFE, 3, 0);
    txn(8'h81, 8'h01, 8'h03, 8'hC0, 0, 0);
    txn(8'hFF, 8'h00, 8'hE7, 8'h00, 1, 0);
    chk("nor_opcode_masked", bus.cod_operacion, 6'h27);
    txn(8'h12, 8'h34, 8'h00, 8'hFF, 2, 0);
    chk("no_overrun_yet", bus.overrun, 0);
    txn(8'h0F, 8'h3C, 8'h24, 8'h0C, 4, 1);
    chk("overrun_set", bus.overrun, 1);
    chk("dropped_byte_no_load", bus.operando_A, 8'h0F);
    txn(8'hA0, 8'h0A, 8'h25, 8'hAA, 2, 0);
    chk("overrun_sticky", bus.overrun, 1);
    send(8'h11);
    send(8'h22);
    send(8'h26);
    exp_starts++;
    repeat (2) @(negedge clk);
    chk("pre_reset_wait", bus.state_o, 4);
    reset_n = 1'b0;
    #1;
    chk("rw_state", bus.state_o, 0);
    chk("rw_busy", bus.busy, 0);
    chk("rw_overrun", bus.overrun, 0);
    chk("rw_a", bus.operando_A, 0);
    chk("rw_b", bus.operando_B, 0);
    chk("rw_op", bus.cod_operacion, 0);
    chk("rw_txdata", bus.tx_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_stray_start", starts, exp_starts);
    send(8'h77);
    chk("ab_loaded_a", bus.operando_A, 8'h77);
    reset_n = 1'b0;
    #1;
    chk("ab_state", bus.state_o, 0);
    chk("ab_a", bus.operando_A, 0);
    @(negedge clk);
    reset_n = 1'b1;
    txn(8'h09, 8'h06, 8'h22, 8'h03, 5, 0);
    for (int t = 0; t < 20; t++) begin
      logic [7:0] a, b, op;
      a = 8'($urandom);
      b = 8'($urandom_range(0, 9));
      op = 8'($urandom_range(0, 5)) == 0 ? 8'($urandom) : {2'($urandom), 6'h20 | 6'($urandom_range(0, 7))};
      txn(a, b, op, alu(a, b, op[5:0]), $urandom_range(0, 50), 0);
    end
    @(negedge clk);
    chk("start_count", starts, exp_starts);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
